// File: rtl/montgomery_reduce_ws.sv
// montgomery_reduce_ws: word-serial Montgomery reduction.
// Streams in T (2*NUM_WORDS words, LSB-first) and streams out T*R^-1 mod N
// (NUM_WORDS words, LSB-first), R = 2^(WORD_SIZE*NUM_WORDS). N is loaded at runtime.
// Build option MONT_LAZY_REDUCE_EN: skip the final compare/subtract; the result
// is left in [0,2N) and the overflow bit is exposed on out_top_out.
// NUM_WORDS must be at least 2.
module montgomery_reduce_ws #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_WORDS = 128
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 n_load_in,
    input  logic [WORD_SIZE-1:0] n_block_in,
    input  logic [WORD_SIZE-1:0] n_prime_in,
    input  logic                 valid_in,
    input  logic [WORD_SIZE-1:0] T_block_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic [WORD_SIZE-1:0] data_block_out,
    output logic                 final_out
`ifdef MONT_LAZY_REDUCE_EN
    ,
    output logic                 out_top_out
`endif
);
    localparam int W   = WORD_SIZE;
    localparam int TAW = $clog2(2 * NUM_WORDS);
    localparam int NAW = $clog2(NUM_WORDS);
    localparam int KW  = $clog2(2 * NUM_WORDS + 1);
    localparam logic [NAW-1:0] N_LAST = NAW'(NUM_WORDS - 1);
    localparam logic [TAW-1:0] T_LAST = TAW'(2 * NUM_WORDS - 1);
    localparam logic [TAW-1:0] T_HI   = TAW'(NUM_WORDS);
    localparam logic [KW-1:0]  K_END  = KW'(2 * NUM_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_T, S_MQ, S_MAC, S_PROP, S_CMP, S_OUT} state_t;

    state_t           state_q;
    logic [NAW-1:0]   n_idx_q, i_q, j_q;
    logic [TAW-1:0]   cnt_q;
    logic [KW-1:0]    k_q;
    logic [W-1:0]     m_q, c_q, np_q;
    logic             t_top_q, gt_q, decided_q, ge_q, borrow_q;
    logic             ready_q, busy_q, valid_q, final_q;
    logic [W-1:0]     data_q;
`ifdef MONT_LAZY_REDUCE_EN
    logic             top_q;
`endif

    // Working storage: T accumulator (low half consumed, high half = result) and modulus.
    logic [W-1:0]     t_mem [2*NUM_WORDS];
    logic [W-1:0]     n_mem [NUM_WORDS];

    logic [TAW-1:0]   t_raddr, t_waddr;
    logic [NAW-1:0]   n_raddr, n_waddr;
    logic [W-1:0]     t_rd, n_rd, t_wdata, n_wdata;
    logic             t_we, n_we;

    logic [W-1:0]     m_d;
    logic [2*W-1:0]   mac_d;
    logic [W:0]       prop_d, sub_d;
    logic             prop_done_d, gt_d, decided_d, ge_d;

    // Read addresses follow the state; one read port per buffer.
    always_comb begin
        t_raddr = '0;
        n_raddr = '0;
        case (state_q)
            S_MQ:         t_raddr = TAW'(i_q);
            S_MAC: begin
                t_raddr = TAW'(i_q) + TAW'(j_q);
                n_raddr = j_q;
            end
            S_PROP:       t_raddr = k_q[TAW-1:0];
            S_CMP, S_OUT: begin
                t_raddr = T_HI + TAW'(j_q);
                n_raddr = j_q;
            end
            default: ;
        endcase
    end

    assign t_rd = t_mem[t_raddr];
    assign n_rd = n_mem[n_raddr];

    // Word arithmetic: quotient digit, multiply-accumulate, carry ripple, subtract, compare.
    always_comb begin
        m_d         = t_rd * np_q;
        mac_d       = (2*W)'(m_q) * (2*W)'(n_rd) + (2*W)'(t_rd) + (2*W)'(c_q);
        prop_d      = (W+1)'(t_rd) + (W+1)'(c_q);
        sub_d       = (W+1)'(t_rd) - (W+1)'(n_rd) - (W+1)'(borrow_q);
        prop_done_d = (k_q == K_END) || !prop_d[W];
        gt_d        = decided_q ? gt_q : (t_rd > n_rd);
        decided_d   = decided_q || (t_rd != n_rd);
        ge_d        = t_top_q || gt_d || !decided_d;
    end

    // Write ports: T stored during load, updated in MAC/PROP; N written only in IDLE.
    always_comb begin
        t_we    = 1'b0;
        t_waddr = '0;
        t_wdata = '0;
        n_we    = 1'b0;
        n_waddr = n_idx_q;
        n_wdata = n_block_in;
        case (state_q)
            S_IDLE: begin
                n_we    = n_load_in;
                t_we    = valid_in;
                t_wdata = T_block_in;
            end
            S_LOAD_T: begin
                t_we    = valid_in;
                t_waddr = cnt_q;
                t_wdata = T_block_in;
            end
            S_MAC: begin
                t_we    = 1'b1;
                t_waddr = t_raddr;
                t_wdata = mac_d[W-1:0];
            end
            S_PROP: begin
                t_we    = (k_q != K_END);
                t_waddr = t_raddr;
                t_wdata = prop_d[W-1:0];
            end
            default: ;
        endcase
    end

    // Buffer storage has no reset; contents are rewritten before every use.
    always_ff @(posedge clk_in) begin
        if (t_we) t_mem[t_waddr] <= t_wdata;
        if (n_we) n_mem[n_waddr] <= n_wdata;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            n_idx_q   <= '0;
            cnt_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            c_q       <= '0;
            np_q      <= '0;
            t_top_q   <= 1'b0;
            gt_q      <= 1'b0;
            decided_q <= 1'b0;
            ge_q      <= 1'b0;
            borrow_q  <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            final_q   <= 1'b0;
            data_q    <= '0;
`ifdef MONT_LAZY_REDUCE_EN
            top_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            final_q <= 1'b0;
            data_q  <= '0;
`ifdef MONT_LAZY_REDUCE_EN
            top_q   <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (n_load_in) n_idx_q <= (n_idx_q == N_LAST) ? '0 : n_idx_q + 1'b1;
                    if (valid_in) begin
                        np_q    <= n_prime_in;
                        cnt_q   <= TAW'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD_T;
                    end
                end
                S_LOAD_T: begin
                    if (valid_in) begin
                        if (cnt_q == T_LAST) begin
                            i_q     <= '0;
                            t_top_q <= 1'b0;
                            ready_q <= 1'b0;
                            state_q <= S_MQ;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_MQ: begin
                    m_q     <= m_d;
                    c_q     <= '0;
                    j_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    c_q <= mac_d[2*W-1:W];
                    if (j_q == N_LAST) begin
                        k_q     <= KW'(i_q) + KW'(NUM_WORDS);
                        state_q <= S_PROP;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_PROP: begin
                    if (k_q == K_END) begin
                        if (c_q != '0) t_top_q <= 1'b1;
                    end else begin
                        c_q <= {{(W-1){1'b0}}, prop_d[W]};
                        k_q <= k_q + 1'b1;
                    end
                    if (prop_done_d) begin
                        if (i_q == N_LAST) begin
`ifdef MONT_LAZY_REDUCE_EN
                            j_q      <= '0;
                            ge_q     <= 1'b0;
                            borrow_q <= 1'b0;
                            state_q  <= S_OUT;
`else
                            j_q       <= N_LAST;
                            gt_q      <= 1'b0;
                            decided_q <= 1'b0;
                            state_q   <= S_CMP;
`endif
                        end else begin
                            i_q     <= i_q + 1'b1;
                            state_q <= S_MQ;
                        end
                    end
                end
                S_CMP: begin
                    gt_q      <= gt_d;
                    decided_q <= decided_d;
                    if (j_q == '0) begin
                        ge_q     <= ge_d;
                        borrow_q <= 1'b0;
                        state_q  <= S_OUT;
                    end else begin
                        j_q <= j_q - 1'b1;
                    end
                end
                S_OUT: begin
                    valid_q  <= 1'b1;
                    data_q   <= ge_q ? sub_d[W-1:0] : t_rd;
                    borrow_q <= sub_d[W];
                    if (j_q == N_LAST) begin
                        final_q <= 1'b1;
`ifdef MONT_LAZY_REDUCE_EN
                        top_q   <= t_top_q;
`endif
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_out      = ready_q;
    assign busy_out       = busy_q;
    assign valid_out      = valid_q;
    assign data_block_out = data_q;
    assign final_out      = final_q;
`ifdef MONT_LAZY_REDUCE_EN
    assign out_top_out    = top_q;
`endif

endmodule
